image_frame_sequencer: RTL and testbench
========================================

// Module: image_frame_sequencer
// PURPOSE
//  Sequences frame readout from the image store: generates read addresses and image select,
//  and streams 24-bit pixels to the display path over a valid/ready handshake.
//  Supports fixed-image mode and slideshow mode (auto-advance image every HOLD_FRAMES frames).
//  Sits between the image store (1-cycle read latency) and the display adapter output stage.
// PARAMETERS
//  IMG_W        100    pixels per line
//  IMG_H        100    lines per frame
//  NUM_IMG      4      number of selectable images (index 0..NUM_IMG-1)
//  PIX_W        24     pixel width (RGB888)
//  ADDR_W       14     read address width (>= clog2(IMG_W*IMG_H))
//  HOLD_FRAMES  60     frames shown per image in slideshow mode (>=1)
// PORTS
//  clk         in   1       clock, all logic on posedge
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       pulse: begin streaming (ignored while busy)
//  stop        in   1       pulse: finish current frame, then go idle
//  mode        in   1       0 = fixed image (sel_img), 1 = slideshow
//  sel_img     in   2       image index for fixed mode / slideshow start image
//  rd_en       out  1       image store read strobe
//  rd_img      out  2       image index for this read
//  rd_addr     out  ADDR_W  linear pixel address y*IMG_W+x
//  rd_data     in   PIX_W   read data, valid exactly 1 cycle after rd_en
//  pix_valid   out  1       output pixel valid
//  pix_ready   in   1       downstream accepts when pix_valid && pix_ready
//  pix_data    out  PIX_W   pixel value
//  pix_sof     out  1       marks first pixel of frame (x=0,y=0)
//  pix_eol     out  1       marks last pixel of line
//  pix_eof     out  1       marks last pixel of frame
//  busy        out  1       high from accepted start until return to IDLE
//  frame_done  out  1       1-cycle pulse when eof pixel is accepted
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; counters, image index, stop latch cleared.
//  - FSM: IDLE -start-> LOAD (latch image = sel_img, clear x/y) -> FETCH -last addr issued-> DRAIN
//    -eof accepted-> LOAD (continue) or IDLE (stop latched). start in non-IDLE states ignored.
//  - Reads: rd_en=1 in FETCH only when (skid occupancy + reads in flight) < 2; no bubbles
//    when pix_ready held high: 1 pixel/cycle sustained after 2-cycle start latency (start->LOAD->rd_en,
//    pix_valid the cycle after rd_en).
//  - Address: x wraps IMG_W-1->0 incrementing y; rd_addr = y*IMG_W+x computed incrementally
//    (no multiplier). Last address = IMG_W*IMG_H-1.
//  - Sideband flags travel with each pixel through the skid; pixel order never changes.
//  - Backpressure: pix_data/flags stable while pix_valid && !pix_ready. No pixel dropped or duplicated.
//  - Image select: rd_img latched at LOAD, constant within a frame; sel_img/mode changes mid-frame
//    take effect only at next LOAD. Slideshow: frame counter counts accepted eof; at HOLD_FRAMES
//    image advances +1, wraps NUM_IMG-1 -> 0, counter clears.
//  - stop: latched in any non-IDLE state; current frame completes in full; then IDLE, busy=0.
//    stop and start same cycle in IDLE: start wins, stop latched (single frame).
//  - Async reset mid-frame: immediate clear; in-flight read data discarded.
// STRUCTURE
//  - Shared package: state enum (IDLE/LOAD/FETCH/DRAIN), PIX_W, default IMG_W/IMG_H, flag bit layout.
//  - Sub-module: pix_skid_buf -- 2-entry FIFO {flags,pixel} with occupancy output; top holds FSM,
//    x/y/addr counters, in-flight tracker, slideshow counter.
// TESTING
//  1 Reset/idle: rst_n low mid-stream -> all outputs 0 same edge; no rd_en until next start.
//  2 Fixed mode, sel_img=2, pix_ready=1, one start+stop: exactly 10000 pixels, rd_img=2,
//    addrs 0..9999 in order, sof on 1st, eol every 100th, eof+frame_done on 10000th, busy drops after.
//  3 Random pix_ready (50%): stream data equals store contents in order; no loss/dup; pix_data
//    stable while stalled; rd_en never issued with occupancy+inflight=2.
//  4 Slideshow, HOLD_FRAMES=2, sel_img=3: frames 1-2 image 3, frames 3-4 image 0 (wrap).
//  5 stop at pixel 5000 -> frame completes to 9999, then IDLE; start while busy ignored.
//  6 sel_img changed mid-frame 1->2 -> frame stays image 1, next frame image 2.

Source files
------------

// File: rtl/image_frame_sequencer_pkg.sv
// Shared types and defaults for the image frame sequencer: FSM states,
// per-pixel sideband flag layout and the slideshow image-advance helper.
package image_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_DRAIN
  } state_e;

  localparam int unsigned PIX_W_DEF = 24;
  localparam int unsigned IMG_W_DEF = 100;
  localparam int unsigned IMG_H_DEF = 100;
  localparam int unsigned FLAG_W    = 3;

  // Sideband flags carried alongside every pixel, MSB first.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_flags_t;

  function automatic logic [1:0] next_img(input logic [1:0] cur, input int unsigned num);
    if (32'(cur) >= num - 1) return '0;
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/image_frame_sequencer_skid.sv
// Two-entry pixel FIFO with fall-through: data arriving into an empty
// buffer is presented the same cycle, so a read strobe yields pix_valid one cycle later.
module pix_skid_buf #(
  parameter int unsigned DATA_W = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              empty, pop, bypass, push, pop_mem;

  assign empty       = (cnt_q == 2'd0);
  assign out_valid_o = !empty || in_valid_i;
  assign out_data_o  = !empty ? mem_q[rd_ptr_q] : (in_valid_i ? in_data_i : '0);
  assign pop         = out_valid_o && out_ready_i;
  // Incoming word consumed directly when the buffer is empty and downstream is ready.
  assign bypass      = empty && in_valid_i && out_ready_i;
  assign push        = in_valid_i && !bypass;
  assign pop_mem     = pop && !empty;
  assign occ_o       = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_mem) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop_mem};
    end
  end

endmodule

// File: rtl/image_frame_sequencer.sv
// Frame readout sequencer: walks the image store in raster order, tags each
// read with sof/eol/eof and streams pixels out through a 2-entry skid buffer.
module image_frame_sequencer
  import image_frame_sequencer_pkg::*;
#(
  parameter int unsigned IMG_W       = IMG_W_DEF,
  parameter int unsigned IMG_H       = IMG_H_DEF,
  parameter int unsigned NUM_IMG     = 4,
  parameter int unsigned PIX_W       = PIX_W_DEF,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic [1:0]        sel_img,
  output logic              rd_en,
  output logic [1:0]        rd_img,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int unsigned SW = PIX_W + FLAG_W;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        rd_img_q, rd_img_d;
  logic [1:0]        slide_img_q, slide_img_d;
  logic [CW-1:0]     frame_cnt_q, frame_cnt_d;
  logic              stop_q, stop_d;
  logic              mode_q, mode_d;
  logic              first_q, first_d;
  logic              inflight_q, inflight_d;
  pix_flags_t        flags_q, flags_d;

  logic [1:0]        occ;
  logic [SW-1:0]     skid_out;
  pix_flags_t        out_flags;
  logic              x_last, y_last, eof_acc;
  logic [1:0]        load_img;

  assign x_last  = (x_q == XW'(IMG_W - 1));
  assign y_last  = (y_q == YW'(IMG_H - 1));
  // Skid occupancy plus the read in flight is everything already committed downstream.
  assign rd_en   = (state_q == ST_FETCH) && ((3'(occ) + 3'(inflight_q)) < 3'd2);
  assign eof_acc = pix_valid && pix_ready && pix_eof;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    rd_img_d    = rd_img_q;
    slide_img_d = slide_img_q;
    frame_cnt_d = frame_cnt_q;
    stop_d      = stop_q;
    mode_d      = mode_q;
    first_d     = first_q;
    inflight_d  = rd_en;
    flags_d     = flags_q;
    load_img    = (first_q || !mode) ? sel_img : slide_img_q;

    if (rd_en) begin
      flags_d.sof = (x_q == '0) && (y_q == '0);
      flags_d.eol = x_last;
      flags_d.eof = x_last && y_last;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          stop_d  = stop;
          first_d = 1'b1;
        end
      end
      ST_LOAD: begin
        rd_img_d    = load_img;
        slide_img_d = load_img;
        mode_d      = mode;
        if (first_q || !mode) frame_cnt_d = '0;
        first_d     = 1'b0;
        x_d         = '0;
        y_d         = '0;
        addr_d      = '0;
        stop_d      = stop_q || stop;
        state_d     = ST_FETCH;
      end
      ST_FETCH: begin
        stop_d = stop_q || stop;
        if (rd_en) begin
          addr_d = addr_q + ADDR_W'(1);
          if (x_last) begin
            x_d = '0;
            if (y_last) begin
              y_d     = '0;
              state_d = ST_DRAIN;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_DRAIN: begin
        stop_d = stop_q || stop;
        if (eof_acc) begin
          if (mode_q) begin
            if (frame_cnt_q == CW'(HOLD_FRAMES - 1)) begin
              frame_cnt_d = '0;
              slide_img_d = next_img(slide_img_q, NUM_IMG);
            end else begin
              frame_cnt_d = frame_cnt_q + CW'(1);
            end
          end
          if (stop_d) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      rd_img_q    <= '0;
      slide_img_q <= '0;
      frame_cnt_q <= '0;
      stop_q      <= 1'b0;
      mode_q      <= 1'b0;
      first_q     <= 1'b0;
      inflight_q  <= 1'b0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      rd_img_q    <= rd_img_d;
      slide_img_q <= slide_img_d;
      frame_cnt_q <= frame_cnt_d;
      stop_q      <= stop_d;
      mode_q      <= mode_d;
      first_q     <= first_d;
      inflight_q  <= inflight_d;
      flags_q     <= flags_d;
    end
  end

  pix_skid_buf #(
    .DATA_W(SW)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (inflight_q),
    .in_data_i  ({flags_q, rd_data}),
    .out_valid_o(pix_valid),
    .out_ready_i(pix_ready),
    .out_data_o (skid_out),
    .occ_o      (occ)
  );

  assign {out_flags, pix_data} = skid_out;
  assign pix_sof    = out_flags.sof;
  assign pix_eol    = out_flags.eol;
  assign pix_eof    = out_flags.eof;
  assign rd_img     = rd_img_q;
  assign rd_addr    = addr_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = eof_acc;

endmodule

// File: tb/tb_image_frame_sequencer.sv
// Self-checking bench for image_frame_sequencer: scenario table plus a
// read-issue scoreboard checked against accepted output pixels.
module tb_image_frame_sequencer;

  localparam int W    = 100;
  localparam int H    = 20;
  localparam int N    = W * H;
  localparam int HOLD = 2;

  logic        clk, rst_n, start, stop, mode, pix_ready;
  logic [1:0]  sel_img, rd_img;
  logic        rd_en, pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_done;
  logic [13:0] rd_addr;
  logic [23:0] rd_data, pix_data;

  image_frame_sequencer #(
    .IMG_W(W), .IMG_H(H), .NUM_IMG(4), .PIX_W(24), .ADDR_W(14), .HOLD_FRAMES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .sel_img(sel_img),
    .rd_en(rd_en), .rd_img(rd_img), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pix_f(input logic [1:0] img, input int idx);
    return {img, idx[7:0] ^ 8'h5A, idx[13:0]};
  endfunction

  // Image store model: 1-cycle read latency, garbage when not strobed.
  always @(posedge clk) rd_data <= rd_en ? pix_f(rd_img, int'(rd_addr)) : 24'hBADBAD;

  typedef struct { logic [1:0] img; int idx; } sb_t;
  sb_t        sb[$];
  logic [1:0] frame_img_q[$];

  int         n_vec = 0, n_err = 0;
  int         issue_idx = 0, acc_idx = 0, done_frames = 0;
  logic [1:0] issue_img = '0;
  bit         mon_en = 0, stall_q = 0;
  logic [26:0] stall_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (mon_en && rst_n) begin
      if (rd_en) begin
        chk("outstanding_lt2", 32'(sb.size() < 2), 1);
        if (issue_idx == 0) begin
          chk("frame_expected", 32'(frame_img_q.size() != 0), 1);
          if (frame_img_q.size() != 0) issue_img = frame_img_q.pop_front();
        end
        chk("rd_img", 32'(rd_img), 32'(issue_img));
        chk("rd_addr", 32'(rd_addr), 32'(issue_idx));
        sb.push_back('{issue_img, issue_idx});
        issue_idx = (issue_idx == N - 1) ? 0 : issue_idx + 1;
      end
      if (stall_q) begin
        chk("valid_held", 32'(pix_valid), 1);
        if (pix_valid) chk("stall_stable", 32'({pix_sof, pix_eol, pix_eof, pix_data}), 32'(stall_val));
      end
      stall_q   = pix_valid && !pix_ready;
      stall_val = {pix_sof, pix_eol, pix_eof, pix_data};
      if (pix_valid && pix_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pix_data", 32'(pix_data), 32'(pix_f(e.img, e.idx)));
          chk("pix_sof", 32'(pix_sof), 32'(e.idx == 0));
          chk("pix_eol", 32'(pix_eol), 32'(e.idx % W == W - 1));
          chk("pix_eof", 32'(pix_eof), 32'(e.idx == N - 1));
          chk("frame_done", 32'(frame_done), 32'(e.idx == N - 1));
          if (e.idx == N - 1) begin
            done_frames++;
            acc_idx = 0;
          end else begin
            acc_idx++;
          end
        end
      end else begin
        chk("frame_done_idle", 32'(frame_done), 0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_rd_img_addr"}, 32'({rd_img, rd_addr}), 0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
    chk({tag, "_pix_data"}, 32'(pix_data), 0);
    chk({tag, "_flags"}, 32'({pix_sof, pix_eol, pix_eof}), 0);
    chk({tag, "_busy_done"}, 32'({busy, frame_done}), 0);
  endtask

  task automatic clear_tb();
    sb.delete();
    frame_img_q.delete();
    issue_idx = 0; acc_idx = 0; done_frames = 0; stall_q = 0;
  endtask

  typedef struct {
    bit         mode;
    logic [1:0] sel;
    logic [1:0] sel_mid;
    bit         rnd_ready;
    int         stop_frame;
    int         stop_pix;   // -1: stop pulsed together with start
    bit         spam_start;
    int         nframes;
    logic [7:0] exp_imgs;   // frame f image at [2f+:2]
  } scen_t;

  scen_t tab[4];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cyc, rd_cnt;
    bit    stop_sent, lat_done;
    scen_t s;

    tab[0] = '{1'b0, 2'd2, 2'd2, 1'b0, 0, -1,    1'b0, 1, 8'h02};
    tab[1] = '{1'b0, 2'd1, 2'd1, 1'b1, 0, N / 2, 1'b1, 1, 8'h01};
    tab[2] = '{1'b1, 2'd3, 2'd3, 1'b0, 3, 5,     1'b0, 4, 8'h0F};
    tab[3] = '{1'b0, 2'd1, 2'd2, 1'b1, 1, 10,    1'b0, 2, 8'h09};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; sel_img = '0; pix_ready = 1'b0;
    #2;
    check_zero("reset_init");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1;

    // Async reset in the middle of a frame.
    frame_img_q.push_back(2'd0);
    pix_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #1 mon_en = 0; rst_n = 1'b0;
    #1 check_zero("reset_mid");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_tb();
    rd_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (rd_en) rd_cnt++;
    end
    chk("no_rd_after_reset", 32'(rd_cnt), 0);
    mon_en = 1;

    for (int i = 0; i < 4; i++) begin
      s = tab[i];
      for (int f = 0; f < s.nframes; f++) frame_img_q.push_back(s.exp_imgs[2*f +: 2]);
      @(posedge clk); #1;
      mode = s.mode; sel_img = s.sel; pix_ready = 1'b1;
      start = 1'b1; stop = (s.stop_pix < 0);
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      chk("busy_after_start", 32'(busy), 1);
      stop_sent = (s.stop_pix < 0);
      lat_done = 0;
      cyc = 0;
      while (cyc < s.nframes * N * 4 + 500) begin
        if (!lat_done && done_frames >= 1) begin
          lat_done = 1;
          if (!s.rnd_ready) chk("first_frame_latency", 32'(cyc), 32'(N + 2));
        end
        if (done_frames == s.nframes && !busy) break;
        pix_ready = s.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        start = 1'b0; stop = 1'b0;
        if (!stop_sent && done_frames == s.stop_frame && acc_idx >= s.stop_pix) begin
          stop = 1'b1; stop_sent = 1;
        end
        if (done_frames == 0 && acc_idx >= N / 2) sel_img = s.sel_mid;
        if (s.spam_start && (cyc % 97) == 50) start = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
      start = 1'b0; stop = 1'b0;
      chk("scenario_finished", 32'(cyc < s.nframes * N * 4 + 500), 1);
      chk("frames_done", 32'(done_frames), 32'(s.nframes));
      chk("busy_dropped", 32'(busy), 0);
      chk("sb_drained", 32'(sb.size()), 0);
      chk("frames_consumed", 32'(frame_img_q.size()), 0);
      repeat (20) @(posedge clk);
      #1 chk("idle_after_stop", 32'({busy, pix_valid}), 0);
      clear_tb();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
